// File: rtl/clock_ui_pkg.sv
// Shared definitions for the clock user-interface button blocks:
// FSM state encoding, clock rate and the derived debounce interval.
package clock_ui_pkg;

   localparam int CLK_HZ               = 100_000_000;
   localparam int DEBOUNCE_10MS_CYCLES = CLK_HZ / 100;

   localparam logic [1:0] ST_IDLE         = 2'd0;
   localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
   localparam logic [1:0] ST_PRESSED      = 2'd2;
   localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

   typedef enum logic [1:0] {
      IDLE         = ST_IDLE,
      PRESS_WAIT   = ST_PRESS_WAIT,
      PRESSED      = ST_PRESSED,
      RELEASE_WAIT = ST_RELEASE_WAIT
   } btn_state_e;

   function automatic int max_int(input int a, input int b);
      if (a > b) begin
         return a;
      end else begin
         return b;
      end
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; both flops clear
// on the asynchronous active-low reset.
module sync_2ff (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta_r;

   // metastability filter chain
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_r <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_r <= d;
         q      <= meta_r;
      end
   end

endmodule

// File: rtl/button_pulse_gen.sv
// Turns a raw push-button into a debounced level and a one-cycle
// change_mode_signal pulse per press, with optional auto-repeat while held.
module button_pulse_gen
   import clock_ui_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES     = DEBOUNCE_10MS_CYCLES,
   parameter int REPEAT_EN           = 0,
   parameter int REPEAT_DELAY_CYCLES = 50_000_000,
   parameter int REPEAT_RATE_CYCLES  = 20_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_in,
   output logic change_mode_signal,
   output logic btn_level
);

   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int REP_W = $clog2(max_int(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES)) + 1;

   localparam logic [DB_W-1:0]  DB_LAST        = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0]  DB_ZERO        = DB_W'(0);
   localparam logic [DB_W-1:0]  DB_ONE         = DB_W'(1);
   localparam logic [REP_W-1:0] REP_DELAY_LAST = REP_W'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [REP_W-1:0] REP_RATE_LAST  = REP_W'(REPEAT_RATE_CYCLES - 1);
   localparam logic [REP_W-1:0] REP_ZERO       = REP_W'(0);
   localparam logic [REP_W-1:0] REP_ONE        = REP_W'(1);

   logic             btn_sync_s;
   btn_state_e       state_r;
   btn_state_e       state_nxt_s;
   logic [DB_W-1:0]  db_cnt_r;
   logic [DB_W-1:0]  db_cnt_nxt_s;
   logic [REP_W-1:0] rep_cnt_r;
   logic [REP_W-1:0] rep_cnt_nxt_s;
   logic             rep_first_r;
   logic             rep_first_nxt_s;
   logic             press_pulse_s;
   logic             rep_pulse_s;

   sync_2ff u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (btn_in),
      .q       (btn_sync_s)
   );

   // state, counters and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r            <= IDLE;
         db_cnt_r           <= DB_ZERO;
         rep_cnt_r          <= REP_ZERO;
         rep_first_r        <= 1'b1;
         change_mode_signal <= 1'b0;
         btn_level          <= 1'b0;
      end else begin
         state_r            <= state_nxt_s;
         db_cnt_r           <= db_cnt_nxt_s;
         rep_cnt_r          <= rep_cnt_nxt_s;
         rep_first_r        <= rep_first_nxt_s;
         change_mode_signal <= press_pulse_s | rep_pulse_s;
         btn_level          <= (state_nxt_s == PRESSED) || (state_nxt_s == RELEASE_WAIT);
      end
   end

   // debounce FSM next-state and press detection
   always_comb begin
      state_nxt_s   = state_r;
      db_cnt_nxt_s  = db_cnt_r;
      press_pulse_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (btn_sync_s) begin
               state_nxt_s  = PRESS_WAIT;
               db_cnt_nxt_s = DB_ZERO;
            end else begin
               state_nxt_s  = IDLE;
            end
         end
         PRESS_WAIT: begin
            if (!btn_sync_s) begin
               state_nxt_s   = IDLE;
            end else if (db_cnt_r == DB_LAST) begin
               state_nxt_s   = PRESSED;
               press_pulse_s = 1'b1;
            end else begin
               db_cnt_nxt_s  = db_cnt_r + DB_ONE;
            end
         end
         PRESSED: begin
            if (!btn_sync_s) begin
               state_nxt_s  = RELEASE_WAIT;
               db_cnt_nxt_s = DB_ZERO;
            end else begin
               state_nxt_s  = PRESSED;
            end
         end
         RELEASE_WAIT: begin
            // a return high before the window expires is release bounce, not a new press
            if (btn_sync_s) begin
               state_nxt_s  = PRESSED;
            end else if (db_cnt_r == DB_LAST) begin
               state_nxt_s  = IDLE;
            end else begin
               db_cnt_nxt_s = db_cnt_r + DB_ONE;
            end
         end
         default: begin
            state_nxt_s  = IDLE;
            db_cnt_nxt_s = DB_ZERO;
         end
      endcase
   end

   // auto-repeat timer: long first interval, then the shorter rate interval
   always_comb begin
      rep_cnt_nxt_s   = rep_cnt_r;
      rep_first_nxt_s = rep_first_r;
      rep_pulse_s     = 1'b0;
      if (REPEAT_EN == 0) begin
         rep_cnt_nxt_s   = REP_ZERO;
         rep_first_nxt_s = 1'b1;
      end else if (press_pulse_s) begin
         rep_cnt_nxt_s   = REP_ZERO;
         rep_first_nxt_s = 1'b1;
      end else if (state_r == PRESSED) begin
         if (rep_cnt_r == (rep_first_r ? REP_DELAY_LAST : REP_RATE_LAST)) begin
            rep_pulse_s     = 1'b1;
            rep_cnt_nxt_s   = REP_ZERO;
            rep_first_nxt_s = 1'b0;
         end else begin
            rep_cnt_nxt_s   = rep_cnt_r + REP_ONE;
         end
      end else if (state_r == RELEASE_WAIT) begin
         rep_cnt_nxt_s   = rep_cnt_r;
      end else begin
         rep_cnt_nxt_s   = REP_ZERO;
         rep_first_nxt_s = 1'b1;
      end
   end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Scoreboard bench: one instance without and one with auto-repeat; expected
// pulse edges are queued by the stimulus and consumed by a pulse monitor.
module tb_button_pulse_gen;

   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RR = 5;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic btn0    = 1'b0;
   logic btn1    = 1'b0;
   logic pulse0, level0, pulse1, level1;
   logic [2:0] mode;

   int edge_n = 0;
   int checks = 0;
   int errors = 0;
   int q0[$];
   int q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   button_pulse_gen #(
      .DEBOUNCE_CYCLES(DB), .REPEAT_EN(0),
      .REPEAT_DELAY_CYCLES(RD), .REPEAT_RATE_CYCLES(RR)
   ) dut0 (
      .clk(clk), .reset_n(reset_n), .btn_in(btn0),
      .change_mode_signal(pulse0), .btn_level(level0)
   );

   button_pulse_gen #(
      .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1),
      .REPEAT_DELAY_CYCLES(RD), .REPEAT_RATE_CYCLES(RR)
   ) dut1 (
      .clk(clk), .reset_n(reset_n), .btn_in(btn1),
      .change_mode_signal(pulse1), .btn_level(level1)
   );

   // consumer mode FSM: 000 -> 001 -> 010 -> 000 on each pulse
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) mode <= 3'd0;
      else if (pulse0) mode <= (mode == 3'd2) ? 3'd0 : mode + 3'd1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic wait_edge(input int e);
      while (edge_n < e) @(negedge clk);
   endtask

   // pulse monitor: every observed pulse must match the head of its queue
   always @(negedge clk) begin
      if (pulse0 === 1'b1) begin
         if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL pulse0_unexpected: pulse at edge %0d, expected none", edge_n);
         end else begin
            check("pulse0_edge", edge_n, q0.pop_front());
         end
      end
      if (pulse1 === 1'b1) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL pulse1_unexpected: pulse at edge %0d, expected none", edge_n);
         end else begin
            check("pulse1_edge", edge_n, q1.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   logic [2:0] mode_tab [3];

   initial begin
      int k, j, a;
      mode_tab = '{3'd1, 3'd2, 3'd0};

      // reset values
      repeat (3) @(negedge clk);
      check("rst_pulse0", pulse0, 1'b0);
      check("rst_level0", level0, 1'b0);
      check("rst_pulse1", pulse1, 1'b0);
      check("rst_level1", level1, 1'b0);
      check("rst_mode", mode, 3'd0);
      reset_n = 1'b1;

      // clean press first sampled at edge 20
      wait_edge(19);
      btn0 = 1'b1;
      k = edge_n + 1;
      q0.push_back(k + DB + 2);
      wait_edge(k + DB + 1);
      check("press_level_before", level0, 1'b0);
      wait_edge(k + DB + 2);
      check("press_level_after", level0, 1'b1);
      wait_edge(k + 30);

      // release glitch of two samples
      btn0 = 1'b0;
      j = edge_n + 1;
      wait_edge(j + 1);
      btn0 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("glitch_level", level0, 1'b1);
      end

      // full release
      btn0 = 1'b0;
      k = edge_n + 1;
      wait_edge(k + DB + 1);
      check("release_level_before", level0, 1'b1);
      wait_edge(k + DB + 2);
      check("release_level_after", level0, 1'b0);
      wait_edge(k + 12);

      // bounce 1,0,1,0 then held
      btn0 = 1'b1; @(negedge clk);
      btn0 = 1'b0; @(negedge clk);
      btn0 = 1'b1; @(negedge clk);
      btn0 = 1'b0; @(negedge clk);
      btn0 = 1'b1;
      k = edge_n + 1;
      q0.push_back(k + DB + 2);
      wait_edge(k + DB + 1);
      check("bounce_level_before", level0, 1'b0);
      wait_edge(k + DB + 2);
      check("bounce_level_after", level0, 1'b1);
      wait_edge(k + 12);
      btn0 = 1'b0;
      k = edge_n + 1;
      wait_edge(k + DB + 4);
      check("bounce_released", level0, 1'b0);

      // reset during PRESS_WAIT, button held through deassertion
      btn0 = 1'b1;
      k = edge_n + 1;
      wait_edge(k + 3);
      reset_n = 1'b0;
      #1;
      check("rst_pw_pulse0", pulse0, 1'b0);
      check("rst_pw_level0", level0, 1'b0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      k = edge_n + 1;
      q0.push_back(k + DB + 2);
      wait_edge(k + DB + 2);
      check("rst_held_level", level0, 1'b1);

      // reset while PRESSED drops the level at once
      wait_edge(k + DB + 6);
      reset_n = 1'b0;
      #1;
      check("rst_pressed_level0", level0, 1'b0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      k = edge_n + 1;
      q0.push_back(k + DB + 2);
      wait_edge(k + DB + 2);
      check("rst2_held_level", level0, 1'b1);
      btn0 = 1'b0;
      k = edge_n + 1;
      wait_edge(k + DB + 3);
      check("rst2_released", level0, 1'b0);

      // auto-repeat on the second instance
      btn1 = 1'b1;
      k = edge_n + 1;
      a = k + DB + 2;
      q1.push_back(a);
      for (int p = 0; p < 6; p++) q1.push_back(a + RD + p * RR);
      wait_edge(a + 35);
      btn1 = 1'b0;
      k = edge_n + 1;
      wait_edge(k + DB + 1);
      check("rep_level_before", level1, 1'b1);
      wait_edge(k + DB + 2);
      check("rep_level_after", level1, 1'b0);
      wait_edge(k + 20);

      // integration: three presses step the mode FSM
      reset_n = 1'b0;
      @(negedge clk);
      check("int_mode_reset", mode, 3'd0);
      reset_n = 1'b1;
      for (int p = 0; p < 3; p++) begin
         btn0 = 1'b1;
         k = edge_n + 1;
         q0.push_back(k + DB + 2);
         wait_edge(k + DB + 3);
         check("int_mode", mode, mode_tab[p]);
         wait_edge(k + 12);
         btn0 = 1'b0;
         k = edge_n + 1;
         wait_edge(k + DB + 4);
      end

      wait_edge(edge_n + 20);
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
